// File: rtl/beat_clock_pkg.sv
// ============================================================================
// Module : beat_clock_pkg
// Brief  : Shared state encodings and game defaults for the round controller
//          and the display logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package beat_clock_pkg;

    localparam int TGT_W           = 5;
    localparam int DEF_ROUND_TICKS = 10;
    localparam int DEF_MIN_TICKS   = 3;
    localparam int DEF_LIVES       = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4,
        ST_OVER = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/beat_clock_round_ctrl_if.sv
// ============================================================================
// Module : beat_clock_round_ctrl_if
// Brief  : Player/generator inputs and display outputs of the round controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface beat_clock_round_ctrl_if
    import beat_clock_pkg::*;
#(
    parameter int TIMER_W = 4,
    parameter int SCORE_W = 8
) ();

    logic               start;
    logic               tick;
    logic               submit;
    logic [TGT_W-1:0]   guess;
    logic [TGT_W-1:0]   rand_in;

    logic [TGT_W-1:0]   target;
    logic [TIMER_W-1:0] time_left;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic               round_active;
    logic               win_pulse;
    logic               lose_pulse;
    logic               game_over;

    modport master (
        output start, tick, submit, guess, rand_in,
        input  target, time_left, score, lives,
        input  round_active, win_pulse, lose_pulse, game_over
    );

    modport slave (
        input  start, tick, submit, guess, rand_in,
        output target, time_left, score, lives,
        output round_active, win_pulse, lose_pulse, game_over
    );

endinterface

`default_nettype wire

// File: rtl/beat_clock_round_timer.sv
// ============================================================================
// Module : beat_clock_round_timer
// Brief  : Per-round countdown register; loads the round length and counts
//          ticks down to zero without wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module beat_clock_round_timer #(
    parameter int TIMER_W = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               load,
    input  wire logic [TIMER_W-1:0] load_val,
    input  wire logic               tick,
    input  wire logic               en,
    output logic      [TIMER_W-1:0] time_left,
    output logic                    expire
);

    logic [TIMER_W-1:0] time_left_q;
    logic [TIMER_W-1:0] time_left_d;

    always_comb begin
        time_left_d = time_left_q;
        if (load) begin
            time_left_d = load_val;
        end else if (tick && en && (time_left_q != '0)) begin
            time_left_d = time_left_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_left_q <= '0;
        end else begin
            time_left_q <= time_left_d;
        end
    end

    assign time_left = time_left_q;
    assign expire    = tick & en & (time_left_q == TIMER_W'(1));

endmodule

`default_nettype wire

// File: rtl/beat_clock_round_ctrl.sv
// ============================================================================
// Module : beat_clock_round_ctrl
// Brief  : Round controller for the binary-guessing game: target pick,
//          countdown, judging, score and lives.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module beat_clock_round_ctrl
    import beat_clock_pkg::*;
#(
    parameter int ROUND_TICKS = DEF_ROUND_TICKS,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int TIMER_W     = 4,
    parameter int SCORE_W     = 8,
    parameter int LIVES       = DEF_LIVES
) (
    input  wire logic               clk,
    input  wire logic               reset,
    beat_clock_round_ctrl_if.slave  bus
);

    state_t             state_q,     state_d;
    logic [TGT_W-1:0]   target_q,    target_d;
    logic [SCORE_W-1:0] score_q,     score_d;
    logic [2:0]         lives_q,     lives_d;
    logic [TIMER_W-1:0] round_len_q, round_len_d;
    logic               first_q,     first_d;

    logic               w_load;
    logic               w_timer_en;
    logic               w_expire;
    logic [TIMER_W-1:0] w_time_left;
    logic               w_rand_ok;

    // A submit pre-empts the tick, so the countdown freezes on judged cycles.
    assign w_timer_en = (state_q == ST_PLAY) & ~bus.submit;

    assign w_rand_ok  = (bus.rand_in != '0) && (first_q || (bus.rand_in != target_q));

    beat_clock_round_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_val  (round_len_q),
        .tick      (bus.tick),
        .en        (w_timer_en),
        .time_left (w_time_left),
        .expire    (w_expire)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        score_d     = score_q;
        lives_d     = lives_q;
        round_len_d = round_len_q;
        first_d     = first_q;
        w_load      = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d     = ST_LOAD;
                    score_d     = '0;
                    lives_d     = 3'(LIVES);
                    round_len_d = TIMER_W'(ROUND_TICKS);
                    first_d     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_rand_ok) begin
                    state_d  = ST_PLAY;
                    target_d = bus.rand_in;
                    first_d  = 1'b0;
                    w_load   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.submit) begin
                    if (bus.guess == target_q) begin
                        state_d     = ST_WIN;
                        score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        round_len_d = (round_len_q > TIMER_W'(MIN_TICKS))
                                    ? round_len_q - TIMER_W'(1)
                                    : TIMER_W'(MIN_TICKS);
                    end else begin
                        state_d = ST_LOSE;
                        lives_d = lives_q - 3'd1;
                    end
                end else if (w_expire) begin
                    state_d = ST_LOSE;
                    lives_d = lives_q - 3'd1;
                end
            end
            ST_WIN: begin
                state_d = ST_LOAD;
            end
            ST_LOSE: begin
                state_d = (lives_q == 3'd0) ? ST_OVER : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            score_q     <= '0;
            lives_q     <= 3'd0;
            round_len_q <= TIMER_W'(ROUND_TICKS);
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            round_len_q <= round_len_d;
            first_q     <= first_d;
        end
    end

    assign bus.target       = target_q;
    assign bus.time_left    = w_time_left;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.round_active = (state_q == ST_PLAY);
    assign bus.win_pulse    = (state_q == ST_WIN);
    assign bus.lose_pulse   = (state_q == ST_LOSE);
    assign bus.game_over    = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: doc/beat_clock_round_ctrl.md
Name: beat_clock_round_ctrl

Overview:
Round controller for the binary-guessing game. Samples the free-running 5-bit random generator to pick each round's target and runs a per-round countdown in game ticks. Judges the player's submitted switch value and tracks score and lives. Sits between the random generator, the tick divider, the switch/button inputs, and the display logic.

Parameters:
ROUND_TICKS, 10, round length in ticks for the first round
MIN_TICKS, 3, floor on round length; must satisfy 1 <= MIN_TICKS <= ROUND_TICKS
TIMER_W, 4, width of time_left and the round-length register; ROUND_TICKS must be < 2^TIMER_W
SCORE_W, 8, score width
LIVES, 3, lives at game start; minimum 1; range 1..7

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  single-cycle pulse; begins a game from IDLE or OVER
tick  in  1  single-cycle countdown strobe from the divider
submit  in  1  single-cycle pulse from the debounced button
guess  in  5  player switch value; sampled only when submit=1
rand_in  in  5  random generator output; changes every clk
target  out  5  current round target
time_left  out  TIMER_W  remaining ticks in the current round
score  out  SCORE_W  rounds won; saturates at the maximum value
lives  out  3  remaining lives
round_active  out  1  high while in PLAY
win_pulse  out  1  high for exactly one cycle per won round
lose_pulse  out  1  high for exactly one cycle per lost round
game_over  out  1  high while in OVER

Behaviour:
- Reset state: IDLE. target=0, time_left=0, score=0, lives=0, round_len=ROUND_TICKS, first flag=1. All pulse and flag outputs are 0.
- Reset has priority over every other input in every state. Asserting it mid-round returns to IDLE with no clock edge required.
- States: IDLE, LOAD, PLAY, WIN, LOSE, OVER.
- IDLE or OVER with start=1 → LOAD. On that edge: score=0, lives=LIVES, round_len=ROUND_TICKS, first=1.
- start is ignored in LOAD, PLAY, WIN and LOSE.
- LOAD: rand_in is rejected when rand_in==0, or when first==0 and rand_in==target. On rejection, stay in LOAD and retry next cycle.
- LOAD accept: target<=rand_in, time_left<=round_len, first<=0, → PLAY.
- PLAY priority order, evaluated each cycle:
  1. submit=1 and guess==target → WIN. On this edge: score+1 (saturating), round_len<=max(round_len-1, MIN_TICKS).
  2. submit=1 and guess!=target → LOSE. On this edge: lives-1.
  3. tick=1 and time_left==1 → LOSE. On this edge: time_left<=0, lives-1.
  4. tick=1 and time_left>1 → time_left-1.
- A correct submit in the same cycle as the final tick is a WIN.
- time_left never underflows. It is never 0 in PLAY.
- tick has no effect outside PLAY. time_left holds its value in WIN and LOSE.
- WIN: win_pulse=1 (Moore decode), then → LOAD.
- LOSE: lose_pulse=1. Next state is OVER if lives==0, else LOAD.
- OVER: game_over=1. Score and target hold for display.
- Latency:
  - submit sampled at edge N → win_pulse/lose_pulse high during cycle N+1, with the score/lives update visible in cycle N+1.
  - New target and time_left visible in cycle N+3 at the earliest (WIN/LOSE → LOAD → PLAY).
  - start → first target visible 2 cycles later, assuming LOAD accepts on its first cycle.
- round_active == (state==PLAY).
- Outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/include beat_clock_pkg holds:
  - state encodings ST_IDLE..ST_OVER (3-bit);
  - target width constant TGT_W=5;
  - default ROUND_TICKS, MIN_TICKS and LIVES values, so the top level and the display logic agree.
- One sub-module: beat_clock_round_timer. It holds the load/tick/expire countdown register.
  - Inputs: load, load_val, tick, en.
  - Outputs: time_left, expire. expire is combinational (tick & en & time_left==1).
- The FSM, score, lives and round_len stay in beat_clock_round_ctrl.

Test Plan:
- Default params. Reset, start, rand_in=21 → 2 cycles later: target=21, time_left=10, lives=3, score=0, round_active=1.
- PLAY target=21, submit with guess=21 → next cycle: win_pulse=1 for one cycle, score=1. Next round: time_left=9. rand_in held at 21 keeps FSM in LOAD until rand_in changes.
- Nine consecutive correct rounds → starting round lengths 10,9,8,7,6,5,4,3,3,3. score=9.
- No submit, 10 ticks → lose_pulse on the cycle after the 10th tick, time_left=0, lives=2. Also: submit guess=20 with target=21 → lose, lives decrements.
- time_left=1, tick and correct submit in the same cycle → WIN, lives unchanged. Also: rand_in=0 in LOAD → held until nonzero.
- Three losses → game_over=1, start ignored mid-round but restarts from OVER with score=0, lives=3. Also: reset asserted mid-PLAY without a clock edge → all outputs 0 immediately.
